fp_add: RTL and testbench
=========================

# fp_add

Pipelined IEEE-754 single-precision floating-point adder/subtractor used by the rasterizer's edge-function stepper. It computes `a+b` or `a-b` and accepts one operation per clock. Each result appears on `y` a fixed `LAT` cycles after issue. The fixed latency lets the issuing FSM tag each operation with its own delay line and collect the result with no handshake.

## Interface
- `LAT`, default 3 (value of `` `FP_ADD_LAT`` from `rasterizer.vh`; legal range 3..8): issue-to-result latency in cycles, equal to the number of register stages.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high; clock `clk`.
- `en` input 1: issue strobe. `a`, `b` and `sub` are sampled on the rising edge that ends a cycle where `en`=1.
- `a` input 32: operand A, IEEE-754 binary32.
- `b` input 32: operand B, IEEE-754 binary32.
- `sub` input 1: 1 computes `a-b`, 0 computes `a+b`. Sampled with `en`.
- `y` output 32: registered result, binary32.

## Operation
- Effective operand B is `{b[31]^sub, b[30:0]}`.
- Result is the exact sum rounded to nearest, ties to even.
- Denormal inputs are flushed to signed zero before use.
- A result whose exponent underflows is flushed to +0.
- Overflow produces ±Inf (`0x7F800000` / `0xFF800000`).
- Any NaN input, or Inf + (−Inf) after the sign flip, produces the canonical quiet NaN `0x7FC00000`.
- Inf + finite = that Inf. Inf + same-sign Inf = Inf.
- Exact cancellation (x + (−x)) gives +0. (−0) + (−0) gives −0. (+0) + (−0) gives +0.
- Each pipeline stage carries a valid bit loaded from `en`.
- `y` loads only when a valid operation reaches the last stage. Otherwise `y` holds its last value.
- There is no stall and no backpressure. Every stage advances every cycle.

## Timing
- Operation issued in cycle t (`en`=1): `y` holds its result throughout cycle t+LAT, and stays there until a later valid result replaces it.
- Back-to-back issue in cycles t, t+1, t+2 gives results in cycles t+LAT, t+LAT+1, t+LAT+2, in order. Throughput is 1 per cycle.
- Issue gaps (`en`=0) do not disturb in-flight operations.
- Reset values: `y`=`0x00000000`, all stage valid bits 0.
- Reset asserted mid-operation discards every in-flight operation. No result from an operation issued before or during reset ever reaches `y`.
- An `en` sampled in the same cycle as `rst` is ignored.
- `y` is driven directly from a flop with no combinational path from inputs. Stage registers themselves need no reset; only the valid bits and `y` do.

## Structure
- Pipeline stages, with extra `LAT`-3 stages inserted as pure delay before the output register:
  - Stage 1: unpack, special-case classify, operand swap by magnitude, exponent difference.
  - Stage 2: alignment shift with guard/round/sticky, then 25-bit add/subtract of the significands.
  - Stage 3: leading-zero count, normalize, RNE round, exponent adjust, pack into `y`.
- Shared package `rasterizer_pkg` (or `rasterizer.vh`) holds `FP_ADD_LAT` and the binary32 constants: `QNAN`=`0x7FC00000`, exponent bias 127, field widths.
- One sub-module is natural: `lzc24`, a leading-zero counter over the 24-bit significand, used in normalization.
- Target size is about 200 to 300 lines of RTL.

## Test plan
- Basic add and subtract, issued one per cycle (LAT=3):
  - `a=0x3F800000`, `b=0x40000000`, `sub`=0 at cycle t → `y=0x40400000` in cycle t+3.
  - Next cycle, `a=0x40400000`, `b=0x3F800000`, `sub`=1 → `y=0x40000000` in cycle t+4.
- Back-to-back three issues `(1.0+1.0)`, `(2.0−0.5)`, `(−3.0+1.0)` → `0x40000000`, `0x3FC00000`, `0xC0000000` on consecutive cycles, in order.
- Rounding:
  - `0x3F800000 + 0x33800000` → `0x3F800000` (tie to even, stays).
  - `0x3F800001 + 0x33800000` → `0x3F800002` (tie to even, rounds up).
- Cancellation and zeros:
  - `0x3F800000 − 0x3F800000` → `0x00000000`.
  - `0x80000000 + 0x80000000` → `0x80000000`.
  - Denormal `0x00000001 + 0x00000000` → `0x00000000`.
- Specials:
  - `0x7F7FFFFF + 0x7F7FFFFF` → `0x7F800000`.
  - `0x7F800000 − 0x7F800000` → `0x7FC00000`.
  - `0x7FC00000 + 1.0` → `0x7FC00000`.
- Reset mid-flight: issue `1.0+2.0` at cycle t, assert `rst` at t+1 → `y` stays `0x00000000` through t+10, and a new issue after reset returns its correct result after `LAT` cycles.

Source files
------------

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: binary32 field widths, constants and pipeline stage records for fp_add.
package fp_add_pkg;
  localparam int FP_ADD_LAT = 3;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef struct packed {
    logic s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp32_t;
  typedef struct packed {
    logic spec;
    logic [31:0] spec_val;
    logic sl;
    logic zsign;
    logic eff_sub;
    logic [EXP_W-1:0] el;
    logic [SIG_W-1:0] ml;
    logic [SIG_W-1:0] ms;
    logic [EXP_W-1:0] diff;
  } s1_t;
  typedef struct packed {
    logic spec;
    logic [31:0] spec_val;
    logic sl;
    logic zsign;
    logic [EXP_W-1:0] el;
    logic [SIG_W+3:0] sum;
  } s2_t;
  function automatic logic [31:0] inf32(input logic s);
    return {s, EXP_MAX, {MAN_W{1'b0}}};
  endfunction
endpackage

// File: rtl/fp_add_if.sv
// fp_add_if: issue strobe, operands and registered result of the fixed-latency adder.
interface fp_add_if;
  logic en;
  logic [31:0] a;
  logic [31:0] b;
  logic sub;
  logic [31:0] y;
  modport master (output en, a, b, sub, input y);
  modport slave (input en, a, b, sub, output y);
endinterface

// File: rtl/fp_add_lzc24.sv
// fp_add_lzc24: leading-zero count of a 24-bit significand; all-zero input yields 24.
module fp_add_lzc24 (
  input  logic [23:0] d_i,
  output logic [4:0]  cnt_o
);
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) cnt_o = d_i[i] ? 5'(23 - i) : cnt_o;
  end
endmodule

// File: rtl/fp_add.sv
// fp_add: pipelined binary32 add/subtract, one issue per cycle, result on y exactly LAT cycles later.
module fp_add
  import fp_add_pkg::*;
#(
  parameter int LAT = FP_ADD_LAT
) (
  input logic clk,
  input logic rst,
  fp_add_if.slave bus
);
  localparam int D = LAT - 3;
  fp32_t fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_ge;
  logic [SIG_W-1:0] sig_a, sig_b;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1_q, v2_q;
  logic [31:0] y_q;
  assign fa = bus.a;
  assign fb = {bus.b[31] ^ bus.sub, bus.b[30:0]};
  assign a_nan = fa.e == EXP_MAX && fa.m != '0;
  assign b_nan = fb.e == EXP_MAX && fb.m != '0;
  assign a_inf = fa.e == EXP_MAX && fa.m == '0;
  assign b_inf = fb.e == EXP_MAX && fb.m == '0;
  // Denormals flush to a zero significand; exponent 0 then orders them as zero.
  assign sig_a = fa.e == '0 ? '0 : {1'b1, fa.m};
  assign sig_b = fb.e == '0 ? '0 : {1'b1, fb.m};
  assign a_ge = {fa.e, sig_a} >= {fb.e, sig_b};
  always_comb begin
    s1_d.spec = a_nan | b_nan | a_inf | b_inf;
    s1_d.spec_val = (a_nan | b_nan | (a_inf & b_inf & (fa.s ^ fb.s))) ? QNAN :
                    a_inf ? inf32(fa.s) : inf32(fb.s);
    s1_d.sl = a_ge ? fa.s : fb.s;
    s1_d.zsign = fa.s & fb.s;
    s1_d.eff_sub = fa.s ^ fb.s;
    s1_d.el = a_ge ? fa.e : fb.e;
    s1_d.ml = a_ge ? sig_a : sig_b;
    s1_d.ms = a_ge ? sig_b : sig_a;
    s1_d.diff = a_ge ? fa.e - fb.e : fb.e - fa.e;
  end
  logic [4:0] sh;
  logic [50:0] wide;
  logic [26:0] al;
  // Aligned small operand: 24 significand bits, guard, round, sticky.
  assign sh = s1_q.diff > 8'd27 ? 5'd27 : s1_q.diff[4:0];
  assign wide = {s1_q.ms, 27'b0} >> sh;
  assign al = {wide[50:25], |wide[24:0]};
  always_comb begin
    s2_d.spec = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sl = s1_q.sl;
    s2_d.zsign = s1_q.zsign;
    s2_d.el = s1_q.el;
    s2_d.sum = s1_q.eff_sub ? {1'b0, s1_q.ml, 3'b0} - {1'b0, al} : {1'b0, s1_q.ml, 3'b0} + {1'b0, al};
  end
  logic [4:0] lz;
  logic carry, rnd, zero;
  logic [26:0] n;
  logic [24:0] mr;
  logic [22:0] man;
  logic signed [9:0] e_n, e_f;
  logic [31:0] r3;
  fp_add_lzc24 u_lzc (.d_i(s2_q.sum[26:3]), .cnt_o(lz));
  assign carry = s2_q.sum[27];
  assign n = carry ? {s2_q.sum[27:2], |s2_q.sum[1:0]} : s2_q.sum[26:0] << lz;
  assign e_n = carry ? $signed({2'b0, s2_q.el}) + 10'sd1 : $signed({2'b0, s2_q.el}) - $signed({5'b0, lz});
  assign rnd = n[2] & (n[3] | n[1] | n[0]);
  assign mr = {1'b0, n[26:3]} + {24'b0, rnd};
  assign man = mr[24] ? mr[23:1] : mr[22:0];
  assign e_f = e_n + $signed({9'b0, mr[24]});
  assign zero = s2_q.sum == '0;
  assign r3 = s2_q.spec ? s2_q.spec_val :
              zero ? {s2_q.zsign, 31'b0} :
              e_f <= 10'sd0 ? '0 :
              e_f >= 10'sd255 ? inf32(s2_q.sl) : {s2_q.sl, e_f[7:0], man};
  logic [D:0][32:0] chain;
  if (D == 0) begin : g_direct
    assign chain = {v2_q, r3};
  end else begin : g_delay
    logic [D-1:0][32:0] dly_q;
    assign chain = {dly_q, v2_q, r3};
    always_ff @(posedge clk)
      for (int i = 0; i < D; i++) dly_q[i] <= {chain[i][32] & ~rst, chain[i][31:0]};
  end
  always_ff @(posedge clk) begin
    v1_q <= bus.en & ~rst;
    v2_q <= v1_q & ~rst;
    s1_q <= s1_d;
    s2_q <= s2_d;
    y_q <= rst ? '0 : chain[D][32] ? chain[D][31:0] : y_q;
  end
  assign bus.y = y_q;
endmodule

// File: tb/tb_fp_add.sv
// tb_fp_add: random and directed stimulus against an exact-arithmetic binary32 reference model.
module tb_fp_add;
  import fp_add_pkg::*;
  localparam int LAT = FP_ADD_LAT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_add_if bus();
  fp_add #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;
  logic chk_on = 1'b0;
  logic [31:0] exp_y = '0;
  int due_q[$];
  logic [31:0] val_q[$];
  logic [31:0] tv_a [16] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40000000,
                             32'hC0400000, 32'h3F800000, 32'h3F800001, 32'h3F800000,
                             32'h80000000, 32'h00000001, 32'h7F7FFFFF, 32'h7F800000,
                             32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h7F800000};
  logic [31:0] tv_b [16] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F000000,
                             32'h3F800000, 32'h33800000, 32'h33800000, 32'h3F800000,
                             32'h80000000, 32'h00000000, 32'h7F7FFFFF, 32'h7F800000,
                             32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7F800000};
  logic tv_s [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] tv_y [16] = '{32'h40400000, 32'h40000000, 32'h40000000, 32'h3FC00000,
                             32'hC0000000, 32'h3F800000, 32'h3F800002, 32'h00000000,
                             32'h80000000, 32'h00000000, 32'h7F800000, 32'h7FC00000,
                             32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h7F800000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, req);
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 0;
  endfunction

  // Magnitude as an integer count of 2^-149 units; denormals count as zero.
  function automatic logic [299:0] mag(input logic [31:0] x);
    if (x[30:23] == 8'h00) return '0;
    return {276'b0, 1'b1, x[22:0]} << (x[30:23] - 8'd1);
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b0, input logic sub);
    logic [31:0] b;
    logic [299:0] ma, mb, m, sig, rem, half;
    logic s;
    int p, e;
    b = {b0[31] ^ sub, b0[30:0]};
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) return 32'h7FC00000;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    ma = mag(a);
    mb = mag(b);
    if (a[31] == b[31]) begin m = ma + mb; s = a[31]; end
    else if (ma >= mb) begin m = ma - mb; s = a[31]; end
    else begin m = mb - ma; s = b[31]; end
    if (m == 0) return (ma == 0 && mb == 0 && a[31] && b[31]) ? 32'h80000000 : 32'h00000000;
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) sig = m << (23 - p);
    else begin
      sig = m >> (p - 23);
      rem = m - (sig << (p - 23));
      half = 300'(1) << (p - 24);
      if (rem > half || (rem == half && sig[0])) sig = sig + 1;
      if (sig[24]) begin sig = sig >> 1; p++; end
    end
    e = p - 149 + BIAS;
    if (e <= 0) return 32'h00000000;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] special(input int i);
    case (i)
      0: return 32'h7F800000;
      1: return 32'hFF800000;
      2: return 32'h7FC00000;
      3: return 32'h00000000;
      4: return 32'h80000000;
      5: return 32'h007FFFFF;
      default: return 32'h7F7FFFFF;
    endcase
  endfunction

  task automatic gen(output logic [31:0] a, output logic [31:0] b);
    int k;
    k = $urandom_range(0, 9);
    a = $urandom;
    b = $urandom;
    if (k < 4) b[30:23] = a[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
    else if (k == 4) b = {a[31:8], 8'($urandom)};
    else if (k == 5) b = a ^ {1'($urandom_range(0, 1)), 31'b0};
    else if (k == 6) b = special($urandom_range(0, 6));
    else if (k == 7) a = special($urandom_range(0, 6));
  endtask

  task automatic drive(input logic e, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.en = e;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
  endtask

  // Scoreboard: each sampled issue is due on y LAT-1 edges after its sampling edge.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      due_q.delete();
      val_q.delete();
      exp_y = '0;
      chk_on = 1'b1;
    end else begin
      if (bus.en) begin
        due_q.push_back(edge_n + LAT - 1);
        val_q.push_back(fp_ref(bus.a, bus.b, bus.sub));
      end
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        exp_y = val_q[0];
        due_q.delete(0);
        val_q.delete(0);
      end
    end
    #1;
    if (chk_on) check("y_stream", bus.y, exp_y);
  end

  initial begin
    logic [31:0] ra, rb;
    bus.en = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_y", bus.y, 32'h00000000);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) check($sformatf("ref_%0d", i), fp_ref(tv_a[i], tv_b[i], tv_s[i]), tv_y[i]);
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
    drive(1'b1, 32'h40400000, 32'h3F800000, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("add_lat", bus.y, 32'h40400000);
    @(negedge clk);
    check("sub_lat", bus.y, 32'h40000000);
    for (int i = 0; i < 16; i++) drive(1'b1, tv_a[i], tv_b[i], tv_s[i]);
    drive(1'b0, '0, '0, 1'b0);
    repeat (LAT + 1) @(negedge clk);
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.a = 32'h40400000;
    bus.b = 32'h3F800000;
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_hold", bus.y, 32'h00000000);
    end
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst", bus.y, 32'h40400000);
    for (int i = 0; i < 3000; i++) begin
      gen(ra, rb);
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      bus.en = $urandom_range(0, 4) != 0;
      bus.a = ra;
      bus.b = rb;
      bus.sub = 1'($urandom_range(0, 1));
    end
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
